// File: rtl/fcp_tx_framer.sv
// FCP update framer: buffers switch flow-control updates in a FIFO, tags each with a
// sequence number at acceptance and streams them as single 128-bit AXIS beats.
module fcp_tx_framer #(
  parameter int QUEUE_INDEX_WIDTH = 16,
  parameter int STAT_WIDTH        = 32,
  parameter int FIFO_ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fcp_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0] fcp_vc,
  input  logic [STAT_WIDTH-1:0]        fcp_fccl,
  input  logic [STAT_WIDTH-1:0]        fcp_qlen,
  input  logic [STAT_WIDTH-1:0]        fcp_fccr,
  output logic [127:0]                 m_axis_fcp_tdata,
  output logic                         m_axis_fcp_tvalid,
  output logic                         m_axis_fcp_tlast,
  input  logic                         m_axis_fcp_tready,
  output logic [FIFO_ADDR_WIDTH:0]     fifo_level,
  output logic                         fifo_afull,
  output logic [31:0]                  drop_count
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] AFULL_THR = (FIFO_ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [127:0]             mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic [15:0]              seq;
  logic                     out_valid;
  logic [127:0]             out_data;
  logic [31:0]              drop_cnt;

  logic         fifo_empty, fifo_full;
  logic         slot_load, pop, bypass, accept, push;
  logic [127:0] new_beat;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                      (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);

  // The slot can take a new beat when it is empty or its current beat leaves this cycle.
  assign slot_load = !out_valid || m_axis_fcp_tready;
  assign pop       = slot_load && !fifo_empty;
  assign bypass    = slot_load && fifo_empty && fcp_valid;
  assign accept    = fcp_valid && (!fifo_full || pop);
  assign push      = accept && !bypass;

  assign new_beat = {seq, 16'(fcp_vc), fcp_fccl, fcp_qlen, fcp_fccr};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= new_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sequence numbers are consumed only by accepted updates, so drops leave no gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seq <= '0;
    else if (accept) seq <= seq + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= '0;
    else if (fcp_valid && !accept && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (slot_load) begin
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
      end else if (bypass) begin
        out_valid <= 1'b1;
        out_data  <= new_beat;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_fcp_tdata  = out_data;
  assign m_axis_fcp_tvalid = out_valid;
  assign m_axis_fcp_tlast  = out_valid;
  assign fifo_level        = wr_ptr - rd_ptr;
  assign fifo_afull        = (fifo_level >= AFULL_THR);
  assign drop_count        = drop_cnt;

endmodule

// File: tb/tb_fcp_tx_framer.sv
// Directed and scoreboarded bench for fcp_tx_framer: packing, backpressure, overflow,
// sequence wrap, mid-stream reset and a random ready/valid stream.
module tb_fcp_tx_framer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fcp_valid;
  logic [15:0]  fcp_vc;
  logic [31:0]  fcp_fccl, fcp_qlen, fcp_fccr;
  logic [127:0] tdata;
  logic         tvalid, tlast, tready;
  logic [4:0]   fifo_level;
  logic         fifo_afull;
  logic [31:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0]  vc;
    logic [31:0]  fccl, qlen, fccr;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] vc;
    logic [31:0] fccl, qlen, fccr;
  } upd_t;

  vec_t vecs[4];
  upd_t sent_q[$];
  int   nsent, nrx, skipped;
  logic [15:0] rx_seq;

  fcp_tx_framer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fcp_valid         (fcp_valid),
    .fcp_vc            (fcp_vc),
    .fcp_fccl          (fcp_fccl),
    .fcp_qlen          (fcp_qlen),
    .fcp_fccr          (fcp_fccr),
    .m_axis_fcp_tdata  (tdata),
    .m_axis_fcp_tvalid (tvalid),
    .m_axis_fcp_tlast  (tlast),
    .m_axis_fcp_tready (tready),
    .fifo_level        (fifo_level),
    .fifo_afull        (fifo_afull),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fcp_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [15:0] vc, input logic [31:0] fccl,
                        input logic [31:0] qlen, input logic [31:0] fccr);
    fcp_valid = 1'b1;
    fcp_vc = vc;
    fcp_fccl = fccl;
    fcp_qlen = qlen;
    fcp_fccr = fccr;
    tick();
    fcp_valid = 1'b0;
  endtask

  task automatic rx_handle();
    chk("rand_seq", tdata[127:112], rx_seq);
    rx_seq = rx_seq + 16'd1;
    while (sent_q.size() > 0 && sent_q[0].fccl != tdata[95:64]) begin
      void'(sent_q.pop_front());
      skipped++;
    end
    if (sent_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL rand_unknown: got beat %h expected a pending update", tdata);
    end else begin
      chk("rand_data", tdata[111:0],
          {sent_q[0].vc, sent_q[0].fccl, sent_q[0].qlen, sent_q[0].fccr});
      void'(sent_q.pop_front());
      nrx++;
    end
  endtask

  initial begin
    vecs[0] = '{16'h0005, 32'h0000_0100, 32'h0000_0020, 32'h0000_00E0,
                128'h0000_0005_00000100_00000020_000000E0};
    vecs[1] = '{16'hFFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678,
                128'h0001_FFFF_FFFFFFFF_00000000_12345678};
    vecs[2] = '{16'h0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0000,
                128'h0002_0000_DEADBEEF_CAFEF00D_00000000};
    vecs[3] = '{16'h8001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003,
                128'h0003_8001_00000001_00000002_00000003};

    rst_n = 1'b0;
    fcp_valid = 1'b0;
    fcp_vc = '0; fcp_fccl = '0; fcp_qlen = '0; fcp_fccr = '0;
    tready = 1'b1;
    #12;
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tdata", tdata, '0);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_afull", fifo_afull, 1'b0);
    chk("rst_drop", drop_count, 32'd0);
    do_reset();

    // table-driven single updates, one-cycle bypass latency
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strobe(vecs[i].vc, vecs[i].fccl, vecs[i].qlen, vecs[i].fccr);
      chk("vec_tvalid", tvalid, 1'b1);
      chk("vec_tlast", tlast, 1'b1);
      chk("vec_tdata", tdata, vecs[i].exp);
      tick();
      chk("vec_idle", tvalid, 1'b0);
    end

    // backpressure: 20 strobes, slot + 16 FIFO entries, 3 drops
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 20; i++) strobe(16'h0007, 32'(i), 32'h0, 32'h0);
    chk("bp_level", fifo_level, 5'd16);
    chk("bp_afull", fifo_afull, 1'b1);
    chk("bp_drop", drop_count, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_stall_valid", tvalid, 1'b1);
      chk("bp_stall_data", tdata, 128'h0000_0007_00000000_00000000_00000000);
      tick();
    end
    // full FIFO with a pop in the same cycle still accepts
    tready = 1'b1;
    strobe(16'h0007, 32'd100, 32'h0, 32'h0);
    tready = 1'b0;
    chk("fullpop_level", fifo_level, 5'd16);
    chk("fullpop_drop", drop_count, 32'd3);
    chk("fullpop_head", tdata[127:112], 16'd1);
    tready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      chk("bp_drain_valid", tvalid, 1'b1);
      chk("bp_drain_seq", tdata[127:112], 16'(k));
      chk("bp_drain_fccl", tdata[95:64], (k <= 16) ? 32'(k) : 32'd100);
      tick();
    end
    chk("bp_drain_idle", tvalid, 1'b0);
    chk("bp_drain_level", fifo_level, 5'd0);

    // almost-full threshold boundary
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 12; i++) strobe(16'h0001, 32'(i), 32'h0, 32'h0);
    chk("afull_lvl11", fifo_level, 5'd11);
    chk("afull_below", fifo_afull, 1'b0);
    strobe(16'h0001, 32'd12, 32'h0, 32'h0);
    chk("afull_lvl12", fifo_level, 5'd12);
    chk("afull_at", fifo_afull, 1'b1);

    // reset mid-operation
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 6; i++) strobe(16'h0002, 32'(i), 32'h0, 32'h0);
    chk("mid_pre_valid", tvalid, 1'b1);
    chk("mid_pre_level", fifo_level, 5'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", tvalid, 1'b0);
    chk("mid_rst_level", fifo_level, 5'd0);
    chk("mid_rst_tdata", tdata, '0);
    tick();
    tick();
    rst_n = 1'b1;
    tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_post_idle", tvalid, 1'b0);
    end
    strobe(16'h0009, 32'hAA, 32'hBB, 32'hCC);
    chk("mid_new_data", tdata, 128'h0000_0009_000000AA_000000BB_000000CC);
    chk("mid_new_drop", drop_count, 32'd0);
    tick();

    // sequence wrap over 65537 accepted updates
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      strobe(16'h0003, 32'(i), 32'h0, 32'h0);
      if (i >= 65535) begin
        chk("wrap_valid", tvalid, 1'b1);
        chk("wrap_seq", tdata[127:112], (i == 65535) ? 16'hFFFF : 16'h0000);
      end
    end
    chk("wrap_drop", drop_count, 32'd0);

    // random valid / ready stream with in-order scoreboard
    do_reset();
    nsent = 0; nrx = 0; skipped = 0; rx_seq = 16'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fcp_valid = ($urandom_range(3) != 0);
      tready    = 1'($urandom_range(1));
      fcp_vc    = 16'($urandom);
      fcp_fccl  = 32'(nsent);
      fcp_qlen  = $urandom;
      fcp_fccr  = $urandom;
      if (fcp_valid) begin
        sent_q.push_back('{fcp_vc, fcp_fccl, fcp_qlen, fcp_fccr});
        nsent++;
      end
      if (tvalid && tready) rx_handle();
      tick();
    end
    fcp_valid = 1'b0;
    tready = 1'b1;
    for (int cyc = 0; cyc < 40 && tvalid; cyc++) begin
      rx_handle();
      tick();
    end
    chk("rand_drain_idle", tvalid, 1'b0);
    chk("rand_drops", drop_count, 32'(skipped + sent_q.size()));
    chk("rand_total", 32'(nrx) + drop_count, 32'(nsent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
